// File: rtl/adc_capture_writer_if.sv
// Host, ADC and SDRAM-side signals of the capture writer, bundled as one port.
// The slave view belongs to adc_capture_writer; the master view is the host/memory side.
// Pure wiring, no state.
interface adc_capture_writer_if;
    logic        start;
    logic        stop;
    logic [21:0] length;
    logic [15:0] adc_data;
    logic        adc_valid;
    logic        mem_req;
    logic        mem_wnr;
    logic [21:0] mem_address;
    logic [15:0] mem_data;
    logic        mem_busy;
    logic        mem_ack;
    logic        capturing;
    logic        done;
    logic        overflow;
    logic [21:0] written;

    modport slave (
        input  start, stop, length, adc_data, adc_valid, mem_busy, mem_ack,
        output mem_req, mem_wnr, mem_address, mem_data,
        output capturing, done, overflow, written
    );

    modport master (
        output start, stop, length, adc_data, adc_valid, mem_busy, mem_ack,
        input  mem_req, mem_wnr, mem_address, mem_data,
        input  capturing, done, overflow, written
    );
endinterface

// File: rtl/adc_capture_writer.sv
// ADC sample capture into a small FIFO, drained as single-word SDRAM writes at consecutive addresses.
// Latency: sample accepted at edge N into an empty FIFO gives mem_req after edge N+1; 3 clocks minimum per word.
// Backpressure: mem_busy/mem_ack stall the drain; samples arriving at a full FIFO are dropped and flag overflow.
// Build option ADC_WRITER_WRAP_EN: circular capture (index wraps at length, only stop ends acceptance).
module adc_capture_writer #(
    parameter int          FIFO_DEPTH_LOG2 = 3,
    parameter logic [21:0] BASE_ADDR       = 22'd0
) (
    input logic                 clk,
    input logic                 rst,
    adc_capture_writer_if.slave bus
);
    localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
    localparam logic [FIFO_DEPTH_LOG2:0] PTR_ONE = {{FIFO_DEPTH_LOG2{1'b0}}, 1'b1};

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_REQ  = 2'd2;
    localparam logic [1:0] S_WAIT = 2'd3;

    logic [1:0]                 state;
    logic [15:0]                fifo_mem [DEPTH];
    logic [FIFO_DEPTH_LOG2:0]   wr_ptr;
    logic [FIFO_DEPTH_LOG2:0]   rd_ptr;
    logic                       fifo_empty;
    logic                       fifo_full;
    logic                       push;
    logic                       pop;
    logic [21:0]                len_q;
    logic [21:0]                index;
    logic                       capturing;
    logic                       done;
    logic                       overflow;
    logic                       mem_req;
    logic [21:0]                mem_address;
    logic [15:0]                mem_data;
    logic [21:0]                written;
`ifndef ADC_WRITER_WRAP_EN
    logic [22:0]                acc_cnt;
    logic [22:0]                acc_target;
`endif

    assign bus.mem_req     = mem_req;
    assign bus.mem_wnr     = 1'b1;
    assign bus.mem_address = mem_address;
    assign bus.mem_data    = mem_data;
    assign bus.capturing   = capturing;
    assign bus.done        = done;
    assign bus.overflow    = overflow;
    assign bus.written     = written;

    // FIFO status and the push/pop decisions; a full FIFO still accepts when it pops in the same cycle.
    always_comb begin
        fifo_empty = (wr_ptr == rd_ptr);
        fifo_full  = (wr_ptr[FIFO_DEPTH_LOG2] != rd_ptr[FIFO_DEPTH_LOG2]) &&
                     (wr_ptr[FIFO_DEPTH_LOG2-1:0] == rd_ptr[FIFO_DEPTH_LOG2-1:0]);
        pop        = (state == S_RUN) && !fifo_empty && !bus.mem_busy;
        push       = capturing && bus.adc_valid && (!fifo_full || pop);
    end

`ifndef ADC_WRITER_WRAP_EN
    // A latched length of zero stands for a full 2^22-sample capture.
    always_comb begin
        acc_target = (len_q == 22'd0) ? 23'h400000 : {1'b0, len_q};
    end
`endif

    // FIFO storage; contents need no reset because the pointers define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr[FIFO_DEPTH_LOG2-1:0]] <= bus.adc_data;
        end
    end

    // Sample acceptance, status flags and the write-request state machine.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            len_q       <= '0;
            index       <= '0;
            capturing   <= 1'b0;
            done        <= 1'b0;
            overflow    <= 1'b0;
            mem_req     <= 1'b0;
            mem_address <= BASE_ADDR;
            mem_data    <= '0;
            written     <= '0;
`ifndef ADC_WRITER_WRAP_EN
            acc_cnt     <= '0;
`endif
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
`ifndef ADC_WRITER_WRAP_EN
                acc_cnt <= acc_cnt + 23'd1;
                if (acc_cnt + 23'd1 == acc_target) begin
                    capturing <= 1'b0;
                end
`endif
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (capturing && bus.adc_valid && !push) begin
                overflow <= 1'b1;
            end
            if (bus.stop && state != S_IDLE) begin
                capturing <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        len_q     <= bus.length;
                        wr_ptr    <= '0;
                        rd_ptr    <= '0;
                        written   <= '0;
                        done      <= 1'b0;
                        overflow  <= 1'b0;
                        index     <= '0;
                        capturing <= 1'b1;
`ifndef ADC_WRITER_WRAP_EN
                        acc_cnt   <= '0;
`endif
                        state     <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (pop) begin
                        mem_data    <= fifo_mem[rd_ptr[FIFO_DEPTH_LOG2-1:0]];
                        mem_address <= BASE_ADDR + index;
                        mem_req     <= 1'b1;
                        state       <= S_REQ;
                    end else if (!capturing && fifo_empty) begin
                        done  <= 1'b1;
                        state <= S_IDLE;
                    end
                end
                S_REQ: begin
                    if (bus.mem_ack) begin
                        mem_req <= 1'b0;
                        written <= written + 22'd1;
`ifdef ADC_WRITER_WRAP_EN
                        index   <= (index == len_q - 22'd1) ? 22'd0 : index + 22'd1;
`else
                        index   <= index + 22'd1;
`endif
                        state   <= S_WAIT;
                    end
                end
                default: begin
                    // Finishing here lets done rise on the edge right after the last ack.
                    if (!capturing && fifo_empty) begin
                        done  <= 1'b1;
                        state <= S_IDLE;
                    end else if (!bus.mem_busy) begin
                        state <= S_RUN;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_adc_capture_writer.sv
// Bench for adc_capture_writer: random SDRAM responder plus sample scoreboard.
// Expected writes come from a list of samples the host sent and an address rule per capture mode.
// Build with ADC_WRITER_WRAP_EN defined to exercise circular capture.
module tb_adc_capture_writer;
    localparam logic [21:0] BASE = 22'h100;

    logic clk;
    logic rst;
    logic hold_busy = 1'b0;
    logic rsp_busy;
    logic no_ack = 1'b0;
    int   ack_lo = 0, ack_hi = 0, busy_lo = 0, busy_hi = 0;
    int   exp_n = -1;
    int   n_checks = 0;
    int   n_errors = 0;
    logic [21:0] got_addr[$];
    logic [15:0] got_data[$];
    logic [15:0] exp_d[$];

    adc_capture_writer_if bus();
    assign bus.mem_busy = hold_busy | rsp_busy;

    adc_capture_writer #(.FIFO_DEPTH_LOG2(3), .BASE_ADDR(BASE)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Address the n-th accepted sample must land at.
    function automatic logic [21:0] exp_addr(input int i, input logic [21:0] len);
        int unsigned eff;
        int unsigned off;
        eff = (len == 22'd0) ? 32'h400000 : 32'(len);
`ifdef ADC_WRITER_WRAP_EN
        off = i % eff;
`else
        off = i;
`endif
        return 22'(32'(BASE) + off);
    endfunction

    // SDRAM model: acks each request after a random delay, then stays busy a little.
    initial begin : responder
        logic [21:0] a0;
        logic [15:0] d0;
        int d, n, b;
        bus.mem_ack = 1'b0;
        rsp_busy    = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.mem_req === 1'b1) begin
                a0 = bus.mem_address;
                d0 = bus.mem_data;
                d  = int'($urandom_range(ack_hi, ack_lo));
                n  = 0;
                while (bus.mem_req === 1'b1 && (no_ack || n < d)) begin
                    @(negedge clk);
                    n++;
                    if (bus.mem_req === 1'b1) begin
                        check_eq("hold_addr", bus.mem_address, a0);
                        check_eq("hold_data", bus.mem_data, d0);
                    end
                end
                if (bus.mem_req === 1'b1) begin
                    bus.mem_ack = 1'b1;
                    rsp_busy    = 1'b1;
                    got_addr.push_back(bus.mem_address);
                    got_data.push_back(bus.mem_data);
                    @(negedge clk);
                    bus.mem_ack = 1'b0;
                    check_eq("req_fall_at_ack", bus.mem_req, 0);
                    if (exp_n >= 0 && got_addr.size() == exp_n) begin
                        check_eq("done_not_at_ack", bus.done, 0);
                        @(negedge clk);
                        check_eq("done_after_ack", bus.done, 1);
                    end
                    b = int'($urandom_range(busy_hi, busy_lo));
                    repeat (b) @(negedge clk);
                    rsp_busy = 1'b0;
                end
            end
        end
    end

    task automatic begin_test(input int n);
        exp_n = n;
        got_addr.delete();
        got_data.delete();
        exp_d.delete();
    endtask

    task automatic do_start(input logic [21:0] len);
        bus.start  = 1'b1;
        bus.length = len;
        @(negedge clk);
        bus.start = 1'b0;
        check_eq("cap_rise", bus.capturing, 1);
        check_eq("start_clr_done", bus.done, 0);
        check_eq("start_clr_ovf", bus.overflow, 0);
        check_eq("start_clr_written", bus.written, 0);
    endtask

    task automatic send(input logic [15:0] d, input int gap, input bit keep);
        bus.adc_data  = d;
        bus.adc_valid = 1'b1;
        if (keep) exp_d.push_back(d);
        @(negedge clk);
        bus.adc_valid = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic pulse_stop();
        bus.stop = 1'b1;
        @(negedge clk);
        bus.stop = 1'b0;
        check_eq("cap_after_stop", bus.capturing, 0);
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (bus.done !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_eq("done_reached", bus.done, 1);
        repeat (6) @(negedge clk);
    endtask

    task automatic check_log(input logic [21:0] len, input logic ovf);
        check_eq("n_writes", got_addr.size(), exp_d.size());
        for (int i = 0; i < exp_d.size() && i < got_addr.size(); i++) begin
            check_eq("wr_addr", got_addr[i], exp_addr(i, len));
            check_eq("wr_data", got_data[i], exp_d[i]);
        end
        check_eq("written", bus.written, exp_d.size());
        check_eq("overflow", bus.overflow, ovf);
        check_eq("done_sticky", bus.done, 1);
        check_eq("cap_idle", bus.capturing, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_req"}, bus.mem_req, 0);
        check_eq({tag, "_wnr"}, bus.mem_wnr, 1);
        check_eq({tag, "_addr"}, bus.mem_address, BASE);
        check_eq({tag, "_data"}, bus.mem_data, 0);
        check_eq({tag, "_cap"}, bus.capturing, 0);
        check_eq({tag, "_done"}, bus.done, 0);
        check_eq({tag, "_ovf"}, bus.overflow, 0);
        check_eq({tag, "_written"}, bus.written, 0);
    endtask

    initial begin : main
        logic [21:0] len;
        int n, k;
        rst = 1'b1;
        bus.start = 1'b0; bus.stop = 1'b0; bus.length = '0;
        bus.adc_data = '0; bus.adc_valid = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        rst = 1'b0;
        @(negedge clk);

        // Slow linear capture with a fast responder; first sample also checks request latency.
        ack_lo = 0; ack_hi = 0; busy_lo = 1; busy_hi = 1;
        begin_test(4);
        do_start(22'd4);
        send(16'hA001, 0, 1'b1);
        check_eq("req_lat_edge_n", bus.mem_req, 0);
        @(negedge clk);
        check_eq("req_lat_edge_n1", bus.mem_req, 1);
        repeat (2) @(negedge clk);
        for (int i = 2; i <= 4; i++) send(16'(16'hA000 + i), 3, 1'b1);
`ifdef ADC_WRITER_WRAP_EN
        pulse_stop();
`else
        check_eq("cap_len_end", bus.capturing, 0);
`endif
        wait_done(300);
        check_log(22'd4, 1'b0);

        // Random lengths, gaps and responder timing, never exceeding the FIFO depth.
        for (int t = 0; t < 8; t++) begin
            ack_lo = 0; ack_hi = 3; busy_lo = 0; busy_hi = 2;
`ifdef ADC_WRITER_WRAP_EN
            len = 22'($urandom_range(4, 1));
            n   = int'($urandom_range(8, 1));
`else
            len = 22'($urandom_range(8, 1));
            n   = int'(len);
`endif
            begin_test(n);
            do_start(len);
            for (int i = 0; i < n; i++)
                send(16'($urandom()), (i == n - 1) ? 0 : int'($urandom_range(4, 0)), 1'b1);
`ifdef ADC_WRITER_WRAP_EN
            pulse_stop();
`else
            k = int'($urandom_range(2, 0));
            for (int i = 0; i < k; i++) send(16'($urandom()), 1, 1'b0);
`endif
            wait_done(400);
            check_log(len, 1'b0);
        end

        // Burst into a stalled SDRAM: eight kept, two dropped.
        ack_lo = 0; ack_hi = 2; busy_lo = 0; busy_hi = 1;
        hold_busy = 1'b1;
        begin_test(8);
        do_start(22'd10);
        for (int i = 0; i < 10; i++) send(16'(16'hB000 + i), 0, i < 8);
        check_eq("ovf_set", bus.overflow, 1);
        check_eq("ovf_cap_on", bus.capturing, 1);
        check_eq("ovf_no_req", bus.mem_req, 0);
        pulse_stop();
        hold_busy = 1'b0;
        wait_done(400);
        check_log(22'd10, 1'b1);

        // Early stop after five samples; later samples ignored.
        begin_test(5);
        do_start(22'd100);
        for (int i = 0; i < 5; i++)
            send(16'($urandom()), (i == 4) ? 0 : int'($urandom_range(3, 0)), 1'b1);
        pulse_stop();
        for (int i = 0; i < 2; i++) send(16'($urandom()), 1, 1'b0);
        wait_done(400);
        check_log(22'd100, 1'b0);

        // Length 0 means 2^22: capture keeps running until stopped.
        begin_test(3);
        do_start(22'd0);
        for (int i = 0; i < 3; i++)
            send(16'($urandom()), (i == 2) ? 0 : int'($urandom_range(3, 0)), 1'b1);
        check_eq("len0_still_cap", bus.capturing, 1);
        pulse_stop();
        wait_done(400);
        check_log(22'd0, 1'b0);

        // Length 3 with seven samples: wraps in circular mode, truncates in linear mode.
`ifdef ADC_WRITER_WRAP_EN
        begin_test(7);
`else
        begin_test(3);
`endif
        do_start(22'd3);
        for (int i = 0; i < 7; i++) begin
`ifdef ADC_WRITER_WRAP_EN
            send(16'($urandom()), (i == 6) ? 0 : 3, 1'b1);
`else
            send(16'($urandom()), (i == 6) ? 0 : 3, i < 3);
`endif
        end
        pulse_stop();
        wait_done(400);
        check_log(22'd3, 1'b0);

        // Reset while a request is pending, then a fresh capture from the base address.
        exp_n = -1;
        no_ack = 1'b1;
        do_start(22'd4);
        send(16'hC0DE, 0, 1'b0);
        k = 0;
        while (bus.mem_req !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        check_eq("req_before_rst", bus.mem_req, 1);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("midreq_rst");
        rst = 1'b0;
        no_ack = 1'b0;
        @(negedge clk);
        begin_test(2);
        do_start(22'd2);
        send(16'h1234, 1, 1'b1);
        send(16'h5678, 0, 1'b1);
        pulse_stop();
        wait_done(300);
        check_log(22'd2, 1'b0);

        // Slow acknowledge: request fields must hold for the whole wait.
        ack_lo = 4; ack_hi = 4; busy_lo = 0; busy_hi = 1;
        begin_test(3);
        do_start(22'd3);
        for (int i = 0; i < 3; i++) send(16'($urandom()), 0, 1'b1);
        pulse_stop();
        wait_done(400);
        check_log(22'd3, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/adc_capture_writer.md
# adc_capture_writer

Capture stage directly upstream of the SDRAM interface: accepts 16-bit ADC samples on a valid strobe, buffers them in a small FIFO, and issues one single-word write request per sample to the SDRAM interface at consecutive addresses. Capture length, arming and stopping are controlled by the host logic. Status outputs report progress, completion and sample loss.

## Interface
- FIFO_DEPTH_LOG2, 3: FIFO depth is 2^FIFO_DEPTH_LOG2 words.
- BASE_ADDR, 22'd0: first SDRAM word address of the capture buffer.
- Clk  in  1  single clock for all logic; rising edge.
- Rst  in  1  reset; synchronous, active-high.
- Start  in  1  one-cycle pulse; latches Length and begins capture.
- Stop  in  1  one-cycle pulse; ends sample acceptance early.
- Length  in  22  capture length in samples; 0 means 2^22.
- ADC_Data  in  16  sample word.
- ADC_Valid  in  1  ADC_Data valid this cycle.
- Mem_Req  out  1  write request to the SDRAM interface.
- Mem_WnR  out  1  constant 1 (write).
- Mem_Address  out  22  word address.
- Mem_Data  out  16  write data.
- Mem_Busy  in  1  SDRAM interface busy.
- Mem_Ack  in  1  SDRAM interface accepted the request.
- Capturing  out  1  samples are being accepted.
- Done  out  1  capture finished and FIFO drained; sticky until Start or Rst.
- Overflow  out  1  at least one sample dropped; sticky until Start or Rst.
- Written  out  22  words written since Start; wraps modulo 2^22.

## Operation
- States: IDLE, RUN, REQ, WAIT.
- IDLE: Mem_Req=0. On Start, the block latches Length, clears the FIFO, Written, Done and Overflow, sets the address index to 0 and Capturing=1, and moves to RUN.
- Sample acceptance: when Capturing=1 and ADC_Valid=1, the sample is pushed if the FIFO is not full. Otherwise it is dropped and Overflow is set. Accepted samples are counted.
- The block clears Capturing after Length samples have been accepted, or on the cycle after a Stop pulse.
- RUN: if the FIFO is non-empty and Mem_Busy=0, the block pops the head word into Mem_Data, drives Mem_Address = BASE_ADDR + index (mod 2^22), sets Mem_Req=1, and moves to REQ.
  - If Capturing=0 and the FIFO is empty, the block sets Done=1 and moves to IDLE.
- REQ: Mem_Req, Mem_Address and Mem_Data are held stable until Mem_Ack=1. On Mem_Ack, Mem_Req drops to 0, index and Written increment, and the state moves to WAIT.
- WAIT: the block stays here until Mem_Busy=0, then returns to RUN.
- Start is ignored outside IDLE. Stop is ignored outside RUN, REQ and WAIT.
- A Stop received while in REQ or WAIT still completes the in-flight write. The FIFO is then fully drained before Done is set.
- Simultaneous FIFO push and pop in the same cycle is allowed, including when the FIFO is full.

## Timing
- Reset values: Mem_Req=0, Mem_WnR=1, Mem_Address=BASE_ADDR, Mem_Data=0, Capturing=0, Done=0, Overflow=0, Written=0; FIFO empty; state IDLE.
- Rst asserted in any state aborts immediately. Mem_Req is 0 on the next edge, and any in-flight write is abandoned.
- A sample accepted at edge N into an empty FIFO, with Mem_Busy=0, gives Mem_Req=1 after edge N+1.
- Mem_Req stays high for at least one cycle and deasserts at the edge on which Mem_Ack=1 is sampled.
- Minimum per-word cycle is 3 clocks (RUN→REQ→WAIT→RUN) when the downstream Ack arrives one cycle after Req and Busy clears one cycle after that.
- Sustained ADC_Valid must arrive at most every 3 cycles to avoid overflow; bursts up to the FIFO depth are absorbed.
- Capturing rises on the edge after Start. Done rises on the edge after the last Mem_Ack, once the FIFO is empty.

## Configuration
- ADC_WRITER_WRAP_EN defined: circular capture.
  - The index returns to 0 after reaching Length-1.
  - Acceptance continues until Stop; Length does not end capture.
  - Written continues counting.
- ADC_WRITER_WRAP_EN undefined: linear capture.
  - Acceptance stops after Length samples, or earlier on Stop.
  - The index never wraps except at the modulo-2^22 address boundary.

## Test plan
- Linear capture: BASE_ADDR=0x100, Length=4, samples 0xA001..0xA004 one every 4 cycles, downstream Ack 1 cycle after Req and Busy 1 cycle after Ack → writes to 0x100..0x103 with matching data, Written=4, Done=1, Overflow=0.
- Burst overflow: FIFO_DEPTH_LOG2=3, Mem_Busy held high, 10 consecutive valid samples → first 8 kept, Overflow=1. After Busy releases, exactly 8 writes occur, then Done (Length=10, Stop pulsed).
- Early stop: Length=100, Stop after 5 accepted samples → exactly 5 writes, Capturing=0 the cycle after Stop, Done after the 5th Ack.
- Wrap mode (ADC_WRITER_WRAP_EN): Length=3, 7 samples, then Stop → addresses BASE, +1, +2, BASE, +1, +2, BASE; Written=7.
- Reset mid-REQ: assert Rst while Mem_Req=1 and Mem_Ack=0 → next cycle Mem_Req=0 and all outputs at reset values; a Start afterwards begins again at BASE_ADDR.
- Handshake hold: Mem_Ack delayed 5 cycles → Mem_Address and Mem_Data are unchanged throughout, and Mem_Req falls exactly at the Ack edge.
